// File: rtl/fsm32_pkg.sv
// Shared types for the fsm32 vector sequencer: controller states and the
// stored test-vector layout {a, b, exp_q}.
package fsm32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic a;
    logic b;
    logic exp_q;
  } vec_t;

  localparam int VEC_W = $bits(vec_t);

endpackage

// File: rtl/fsm32_vec_buf.sv
// Test-vector store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fsm32_vec_buf
  import fsm32_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  vec_t                     wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output vec_t                     rd_data
);

  vec_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read so stimulus reaches a/b in the same cycle as the index.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fsm32_seq.sv
// Vector sequencer for an fsm32 instance: loads {a, b, exp_q} vectors, plays
// them out one per cycle and counts mismatches on q one cycle later.
module fsm32_seq
  import fsm32_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [2:0]               wr_data,
  input  logic                     clear,
  input  logic                     start,
  output logic                     a,
  output logic                     b,
  input  logic                     q,
  output logic                     busy,
  output logic                     done,
  output logic [CW-1:0]            err_count,
  output logic [$clog2(DEPTH):0]   vec_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  state_t          state_reg, state_next;
  logic [NW-1:0]   count_reg, count_next;
  logic [AW-1:0]   idx_reg, idx_next;
  logic [CW-1:0]   err_reg, err_next;
  logic            exp_reg, exp_next;
  logic            cmp_reg, cmp_next;
  logic            wr_en;
  logic            mismatch;
  logic            last_entry;
  vec_t            rd_vec;

  fsm32_vec_buf #(
    .DEPTH (DEPTH)
  ) u_vec_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (count_reg[AW-1:0]),
    .wr_data (vec_t'(wr_data)),
    .rd_addr (idx_reg),
    .rd_data (rd_vec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      idx_reg   <= '0;
      err_reg   <= '0;
      exp_reg   <= 1'b0;
      cmp_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      idx_reg   <= idx_next;
      err_reg   <= err_next;
      exp_reg   <= exp_next;
      cmp_reg   <= cmp_next;
    end
  end

  // cmp_reg/exp_reg carry the expectation of the entry driven last cycle.
  assign mismatch   = cmp_reg && (q != exp_reg);
  assign last_entry = ({1'b0, idx_reg} == (count_reg - 1'b1));

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    idx_next   = idx_reg;
    err_next   = err_reg;
    exp_next   = exp_reg;
    cmp_next   = cmp_reg;
    wr_en      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (clear) begin
          count_next = '0;
        end else begin
          // A write accepted together with start is appended and played.
          if (wr_valid && wr_ready) begin
            wr_en      = 1'b1;
            count_next = count_reg + 1'b1;
          end
          if (start && (count_reg != '0)) begin
            state_next = ST_RUN;
            idx_next   = '0;
            err_next   = '0;
            cmp_next   = 1'b0;
          end
        end
      end

      ST_RUN: begin
        exp_next = rd_vec.exp_q;
        cmp_next = 1'b1;
        if (mismatch && (err_reg != '1)) begin
          err_next = err_reg + 1'b1;
        end
        idx_next = idx_reg + 1'b1;
        if (last_entry) begin
          state_next = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (mismatch && (err_reg != '1)) begin
          err_next = err_reg + 1'b1;
        end
        cmp_next   = 1'b0;
        state_next = ST_DONE;
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Handshake and stimulus outputs are held low while reset is asserted.
  assign wr_ready  = reset && (state_reg == ST_IDLE) && (count_reg < NW'(DEPTH));
  assign a         = reset && (state_reg == ST_RUN) && rd_vec.a;
  assign b         = reset && (state_reg == ST_RUN) && rd_vec.b;
  assign busy      = reset && ((state_reg == ST_RUN) || (state_reg == ST_DRAIN));
  assign done      = reset && (state_reg == ST_DONE);
  assign err_count = err_reg;
  assign vec_count = count_reg;

endmodule

// File: tb/tb_fsm32_seq.sv
// Directed bench for fsm32_seq: a small reference fsm drives q from the
// sequencer's a/b; a second instance with CW=2 checks counter saturation.
module tb_fsm32_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [2:0]  wr_data = '0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        a, b;
  logic        q;
  logic        busy, done;
  logic [7:0]  err_count;
  logic [4:0]  vec_count;

  logic        wr_valid2 = 1'b0;
  logic        wr_ready2;
  logic [2:0]  wr_data2 = '0;
  logic        clear2 = 1'b0;
  logic        start2 = 1'b0;
  logic        a2, b2;
  logic        q2 = 1'b0;
  logic        busy2, done2;
  logic [1:0]  err_count2;
  logic [3:0]  vec_count2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fsm32_seq #(.DEPTH(16), .CW(8)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .clear(clear), .start(start), .a(a), .b(b), .q(q),
    .busy(busy), .done(done), .err_count(err_count), .vec_count(vec_count)
  );

  fsm32_seq #(.DEPTH(8), .CW(2)) dut2 (
    .clk(clk), .reset(reset), .wr_valid(wr_valid2), .wr_ready(wr_ready2),
    .wr_data(wr_data2), .clear(clear2), .start(start2), .a(a2), .b(b2), .q(q2),
    .busy(busy2), .done(done2), .err_count(err_count2), .vec_count(vec_count2)
  );

  // Reference fsm32: q is a registered bit loaded with b whenever a is high.
  always_ff @(posedge clk) begin
    if (!reset) q <= 1'b0;
    else if (a) q <= b;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  // All tasks are entered just after a falling edge and leave just after one.
  task automatic write_vec(input logic [2:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic run1(output int busy_n, output int done_n, output logic [1:0] ab0);
    busy_n = 0;
    done_n = 0;
    ab0    = '0;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 0) ab0 = {a, b};
      if (busy) busy_n++;
      if (done) done_n++;
      if ((done_n > 0) && !done) break;
    end
  endtask

  task automatic watch_idle(input int cycles, output int busy_n, output int done_n);
    busy_n = 0;
    done_n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
    end
  endtask

  logic [2:0] good_vec [4];
  logic [2:0] bad_vec  [4];
  int         bn, dn, acc;
  logic [1:0] ab0;

  initial begin
    good_vec[0] = 3'b111; good_vec[1] = 3'b001; good_vec[2] = 3'b100; good_vec[3] = 3'b010;
    bad_vec[0]  = 3'b111; bad_vec[1]  = 3'b001; bad_vec[2]  = 3'b101; bad_vec[3]  = 3'b010;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ab", {a, b}, 0);
    check("rst_vec_count", vec_count, 0);
    check("rst_err_count", err_count, 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_wr_ready", wr_ready, 1);

    // Golden run: no mismatches
    for (int i = 0; i < 4; i++) write_vec(good_vec[i]);
    check("load4_vec_count", vec_count, 4);
    run1(bn, dn, ab0);
    check("good_busy_cycles", bn, 5);
    check("good_done_pulses", dn, 1);
    check("good_ab_entry0", ab0, 3);
    check("good_err_count", err_count, 0);

    // Entry 2 expectation inverted, then replay without reload
    do_clear();
    for (int i = 0; i < 4; i++) write_vec(bad_vec[i]);
    run1(bn, dn, ab0);
    check("bad_busy_cycles", bn, 5);
    check("bad_err_count", err_count, 1);
    repeat (3) @(negedge clk);
    check("bad_err_hold", err_count, 1);
    run1(bn, dn, ab0);
    check("replay_done_pulses", dn, 1);
    check("replay_err_count", err_count, 1);
    check("replay_vec_count", vec_count, 4);

    // Fill past capacity
    do_clear();
    acc = 0;
    for (int i = 0; i < 18; i++) begin
      wr_valid = 1'b1;
      wr_data  = 3'(i);
      if (wr_ready) acc++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("full_accepted", acc, 16);
    check("full_vec_count", vec_count, 16);
    check("full_wr_ready", wr_ready, 0);

    // Start on an empty buffer; clear racing start
    do_clear();
    check("clear_vec_count", vec_count, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    watch_idle(5, bn, dn);
    check("empty_start_busy", bn, 0);
    check("empty_start_done", dn, 0);
    write_vec(3'b111);
    write_vec(3'b001);
    check("pre_race_vec_count", vec_count, 2);
    clear = 1'b1;
    start = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    start = 1'b0;
    check("race_vec_count", vec_count, 0);
    watch_idle(5, bn, dn);
    check("race_busy", bn, 0);
    check("race_done", dn, 0);

    // Reset in RUN cycle 2 (entry 0 expectation wrong so err is nonzero first)
    write_vec(3'b110);
    write_vec(3'b001);
    write_vec(3'b100);
    write_vec(3'b010);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("abort_run0_busy", busy, 1);
    repeat (2) @(negedge clk);
    check("abort_run2_err", err_count, 1);
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_ab", {a, b}, 0);
    check("abort_err_count", err_count, 0);
    reset = 1'b1;
    watch_idle(8, bn, dn);
    check("abort_done_never", dn, 0);
    check("abort_busy_never", bn, 0);

    // CW=2 instance: 8 wrong expectations saturate at 3
    for (int i = 0; i < 8; i++) begin
      wr_valid2 = 1'b1;
      wr_data2  = {1'(i & 1), 1'((i >> 1) & 1), 1'b1};
      @(negedge clk);
    end
    wr_valid2 = 1'b0;
    check("sat_vec_count", vec_count2, 8);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    bn = 0;
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (busy2) bn++;
      if (done2) dn++;
      if ((dn > 0) && !done2) break;
    end
    check("sat_busy_cycles", bn, 9);
    check("sat_done_pulses", dn, 1);
    check("sat_err_count", err_count2, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fsm32_seq.md
FSM32_SEQ -- requirements
Module: fsm32_seq

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of stored test vectors (power of two, 2..256).
REQ-002 SHALL have parameter CW, default 8, meaning error-counter width.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port wr_valid  input  1  vector-write request.
REQ-006 SHALL have port wr_ready  output  1  buffer accepts write.
REQ-007 SHALL have port wr_data  input  3  vector {a, b, exp_q}.
REQ-008 SHALL have port clear  input  1  empty the buffer.
REQ-009 SHALL have port start  input  1  begin playback.
REQ-010 SHALL have port a  output  1  stimulus bit a to the fsm32 instance.
REQ-011 SHALL have port b  output  1  stimulus bit b to the fsm32 instance.
REQ-012 SHALL have port q  input  1  fsm32 output under check.
REQ-013 SHALL have port busy  output  1  playback in progress.
REQ-014 SHALL have port done  output  1  one-cycle end-of-run pulse.
REQ-015 SHALL have port err_count  output  CW  mismatches in last run.
REQ-016 SHALL have port vec_count  output  $clog2(DEPTH)+1  stored vectors.

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN, DONE.
REQ-018 SHALL assert wr_ready only in IDLE with vec_count < DEPTH.
REQ-019 SHALL store wr_data at index vec_count and increment vec_count on wr_valid && wr_ready.
REQ-020 SHALL, on clear in IDLE, set vec_count to 0; clear outside IDLE is ignored; clear wins over a simultaneous write or start.
REQ-021 SHALL go IDLE->RUN on start with vec_count > 0, zeroing err_count and play index in the same edge; start with vec_count = 0 is ignored.
REQ-022 SHALL, in RUN cycle k (k = 0..vec_count-1), drive {a,b} from entry k.
REQ-023 SHALL compare q in cycle k+1 against exp_q of entry k (one-cycle fixed latency) and increment err_count on inequality.
REQ-024 SHALL saturate err_count at 2^CW-1.
REQ-025 SHALL go RUN->DRAIN after driving the last entry, perform the final compare in DRAIN, then go DONE.
REQ-026 SHALL assert done for exactly the DONE cycle, then return to IDLE; err_count holds until the next start.
REQ-027 SHALL drive a=b=0 outside RUN; busy=1 in RUN and DRAIN only.
REQ-028 SHALL ignore start, wr_valid and clear while busy.
REQ-029 SHALL retain buffer contents after a run so start replays the same vectors.

Reset
REQ-030 SHALL, while reset=0 at a rising edge, force state IDLE, vec_count=0, err_count=0, a=b=0, busy=0, done=0, wr_ready=0 in that cycle.
REQ-031 SHALL abort any run mid-operation on reset without asserting done.
REQ-032 SHALL leave buffer storage uninitialised by reset.

Structure
REQ-033 SHALL take the state enum and the vector struct {a, b, exp_q} from shared package fsm32_pkg.
REQ-034 SHALL place storage in sub-module fsm32_vec_buf (write port, asynchronous read port).

Verification
REQ-035 SHALL cover: write 4 vectors with exp_q matching a golden fsm32 model, start -> busy for 5 cycles, done pulse, err_count=0.
REQ-036 SHALL cover: the same 4 vectors with entry 2 exp_q inverted -> err_count=1; replay without reload -> err_count=1.
REQ-037 SHALL cover: write DEPTH+2 vectors -> wr_ready=0 after the 16th, vec_count=16.
REQ-038 SHALL cover: start with vec_count=0 -> stays IDLE, no done; clear plus start in the same cycle -> vec_count=0, no run.
REQ-039 SHALL cover: reset=0 at RUN cycle 2 -> next cycle IDLE, a=b=0, done never asserted, err_count=0.
REQ-040 SHALL cover: CW=2 with all 8 expectations wrong -> err_count saturates at 3.
